// File: rtl/network_runner_if.sv
// Host/network bundle for network_runner.
//   master : host side, drives start/pixels and the network's spikes
//   slave  : network_runner, drives the network controls and run results
interface network_runner_if #(
  parameter int HEIGHT      = 7,
  parameter int NUM_CLASSES = 2,
  parameter int CNT_W       = 10
);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic                         start;
  logic [HEIGHT-1:0]            pixels;
  logic [HEIGHT-1:0]            net_pixels;
  logic                         net_rst;
  logic                         net_en;
  logic [NUM_CLASSES-1:0]       net_spikes;
  logic                         busy;
  logic                         done;
  logic [IDX_W-1:0]             winner;
  logic                         no_spike;
  logic [NUM_CLASSES*CNT_W-1:0] spike_counts;

  modport slave (
    input  start, pixels, net_spikes,
    output net_pixels, net_rst, net_en, busy, done, winner, no_spike, spike_counts
  );

  modport master (
    output start, pixels, net_spikes,
    input  net_pixels, net_rst, net_en, busy, done, winner, no_spike, spike_counts
  );
endinterface

// File: rtl/network_runner.sv
// Run controller for the spiking pixel classifier.
// Latches a frame on start, holds the network in reset for one cycle,
// enables it for WINDOW cycles while counting spikes per class, then scans
// the counts for the argmax and pulses done with the result.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - network_runner_if.slave (host request/result + network controls)
//
// state   | meaning
// IDLE    | waiting for start, previous results held, network held in reset
// CLEAR   | one cycle of network reset after a new frame is latched
// RUN     | network enabled for WINDOW cycles, spikes counted per class
// RESOLVE | one cycle per class, sequential argmax scan
// DONE    | one-cycle done pulse
module network_runner #(
  parameter int HEIGHT      = 7,
  parameter int NUM_CLASSES = 2,
  parameter int WINDOW      = 512,
  parameter int CNT_W       = 10
) (
  input logic              clk,
  input logic              rst,
  network_runner_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_CLASSES);
  // +1 keeps the width non-zero when WINDOW is 1
  localparam int WIN_W = $clog2(WINDOW + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]                   state;
  logic [HEIGHT-1:0]            pix_q;
  logic [CNT_W-1:0]             cnt [NUM_CLASSES];
  logic [WIN_W-1:0]             win_cnt;
  logic [IDX_W-1:0]             scan_k;
  logic [IDX_W-1:0]             best_idx;
  logic [CNT_W-1:0]             best_cnt;
  logic [IDX_W-1:0]             winner_q;
  logic                         no_spike_q;
  logic [NUM_CLASSES*CNT_W-1:0] cnt_flat;

  logic [CNT_W-1:0] scan_cnt;
  logic             take_k;
  logic [IDX_W-1:0] nxt_idx;
  logic [CNT_W-1:0] nxt_cnt;

  // Strict compare: ties keep the earlier (lower) index. best_cnt starts
  // at 0, so an all-zero run leaves best_idx at 0.
  always_comb begin
    scan_cnt = cnt[scan_k];
    take_k   = (scan_cnt > best_cnt);
    nxt_idx  = take_k ? scan_k : best_idx;
    nxt_cnt  = take_k ? scan_cnt : best_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pix_q      <= '0;
      win_cnt    <= '0;
      scan_k     <= '0;
      best_idx   <= '0;
      best_cnt   <= '0;
      winner_q   <= '0;
      no_spike_q <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pix_q      <= bus.pixels;
            // results cleared here so they already read zero during CLEAR
            winner_q   <= '0;
            no_spike_q <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          win_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            if (bus.net_spikes[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
          end
          if (win_cnt == WIN_W'(WINDOW - 1)) begin
            scan_k   <= '0;
            best_idx <= '0;
            best_cnt <= '0;
            state    <= S_RESOLVE;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        S_RESOLVE: begin
          best_idx <= nxt_idx;
          best_cnt <= nxt_cnt;
          if (scan_k == IDX_W'(NUM_CLASSES - 1)) begin
            winner_q   <= nxt_idx;
            no_spike_q <= (nxt_cnt == '0);
            state      <= S_DONE;
          end else begin
            scan_k <= scan_k + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_CLASSES; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
  end

  // Controls decode straight from the state register; net_en and net_rst
  // are complementary so they can never both be high.
  assign bus.net_en       = (state == S_RUN);
  assign bus.net_rst      = (state != S_RUN);
  assign bus.busy         = (state == S_CLEAR) || (state == S_RUN) || (state == S_RESOLVE);
  assign bus.done         = (state == S_DONE);
  assign bus.net_pixels   = pix_q;
  assign bus.winner       = winner_q;
  assign bus.no_spike     = no_spike_q;
  assign bus.spike_counts = cnt_flat;
endmodule

// File: tb/tb_network_runner.sv
module tb_network_runner;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  network_runner_if #(.HEIGHT(7), .NUM_CLASSES(3), .CNT_W(4)) bus ();

  network_runner #(
    .HEIGHT(7), .NUM_CLASSES(3), .WINDOW(16), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-RUN-cycle spike stimulus and per-cycle observations of the last run
  logic [2:0]  spk_tbl [16];
  logic [31:0] en_mask;
  logic [31:0] done_mask;
  logic [31:0] busy_mask;
  int          overlap;
  logic [11:0] cnt_at [26];
  logic [6:0]  np_at  [26];
  logic        nrst_at [26];

  // Cycle 0 is the cycle whose closing edge samples start=1; cycle n is
  // observed 1 time unit after the n-th following edge.
  task automatic drive_run(input logic [6:0] pix, input logic [31:0] start_mask,
                           input int rst_cyc, input logic chg_pix);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pixels = pix; bus.net_spikes = 3'b000;
    en_mask = '0; done_mask = '0; busy_mask = '0; overlap = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      en_mask[n]   = bus.net_en;
      done_mask[n] = bus.done;
      busy_mask[n] = bus.busy;
      cnt_at[n]    = bus.spike_counts;
      np_at[n]     = bus.net_pixels;
      nrst_at[n]   = bus.net_rst;
      if (bus.net_en && bus.net_rst) overlap++;
      bus.start = start_mask[n];
      rst = (n == rst_cyc);
      if (chg_pix) bus.pixels = 7'b0000000;
      bus.net_spikes = (n >= 2 && n <= 17) ? spk_tbl[n-2] : 3'b000;
    end
    bus.start = 1'b0; rst = 1'b0; bus.net_spikes = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.pixels = 7'h7F; bus.net_spikes = 3'b111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.net_rst !== 1'b1 || bus.net_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d: rst=%b en=%b busy=%b done=%b, need 1 0 0 0",
                 n, bus.net_rst, bus.net_en, bus.busy, bus.done);
      end
    end
    checks++;
    if (bus.winner !== 2'd0 || bus.spike_counts !== 12'h000 || bus.no_spike !== 1'b0 || bus.net_pixels !== 7'h00) begin
      errors++;
      $display("FAIL reset_results: winner=%0d counts=%h no_spike=%b pix=%b, need 0 000 0 0000000",
               bus.winner, bus.spike_counts, bus.no_spike, bus.net_pixels);
    end
    bus.net_spikes = 3'b000;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 16; i++) spk_tbl[i] = 3'b010;
    drive_run(7'b1010101, 32'h0, -1, 1'b0);
    checks++;
    if (np_at[1] !== 7'b1010101) begin
      errors++; $display("FAIL sat_pixels: got %b need 1010101", np_at[1]);
    end
    checks++;
    if (en_mask !== 32'h0003FFFC) begin
      errors++; $display("FAIL sat_en_window: got %h need 0003fffc", en_mask);
    end
    checks++;
    if (done_mask !== 32'h00200000) begin
      errors++; $display("FAIL sat_done_cycle: got %h need 00200000", done_mask);
    end
    checks++;
    if (busy_mask !== 32'h001FFFFE) begin
      errors++; $display("FAIL sat_busy: got %h need 001ffffe", busy_mask);
    end
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL sat_en_rst_overlap: got %0d cycles need 0", overlap);
    end
    checks++;
    if (bus.spike_counts !== 12'h0F0 || bus.winner !== 2'd1 || bus.no_spike !== 1'b0) begin
      errors++;
      $display("FAIL sat_result: counts=%h winner=%0d no_spike=%b, need 0f0 1 0",
               bus.spike_counts, bus.winner, bus.no_spike);
    end
  endtask

  task automatic test_tie();
    for (int i = 0; i < 16; i++) spk_tbl[i] = 3'b000;
    for (int i = 0; i < 5; i++) spk_tbl[i] = 3'b101;
    for (int i = 5; i < 8; i++) spk_tbl[i] = 3'b010;
    drive_run(7'b0110011, 32'h0, -1, 1'b0);
    checks++;
    if (bus.spike_counts !== 12'h535 || bus.winner !== 2'd0 || bus.no_spike !== 1'b0) begin
      errors++;
      $display("FAIL tie_result: counts=%h winner=%0d no_spike=%b, need 535 0 0",
               bus.spike_counts, bus.winner, bus.no_spike);
    end
  endtask

  task automatic test_last_class_wins();
    for (int i = 0; i < 16; i++) spk_tbl[i] = 3'b000;
    for (int i = 0; i < 4; i++) spk_tbl[i] = 3'b100;
    spk_tbl[15] = 3'b001;
    spk_tbl[14] = 3'b001;
    drive_run(7'b0000001, 32'h0, -1, 1'b0);
    checks++;
    if (bus.spike_counts !== 12'h402 || bus.winner !== 2'd2 || bus.no_spike !== 1'b0) begin
      errors++;
      $display("FAIL last_class_result: counts=%h winner=%0d no_spike=%b, need 402 2 0",
               bus.spike_counts, bus.winner, bus.no_spike);
    end
  endtask

  task automatic test_no_spike();
    for (int i = 0; i < 16; i++) spk_tbl[i] = 3'b000;
    drive_run(7'b1111111, 32'h0, -1, 1'b0);
    checks++;
    if (done_mask !== 32'h00200000) begin
      errors++; $display("FAIL nospike_done_cycle: got %h need 00200000", done_mask);
    end
    checks++;
    if (bus.spike_counts !== 12'h000 || bus.winner !== 2'd0 || bus.no_spike !== 1'b1) begin
      errors++;
      $display("FAIL nospike_result: counts=%h winner=%0d no_spike=%b, need 000 0 1",
               bus.spike_counts, bus.winner, bus.no_spike);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] sm;
    logic        seen;
    sm = '0; sm[5] = 1'b1; sm[21] = 1'b1; sm[22] = 1'b1;
    for (int i = 0; i < 16; i++) spk_tbl[i] = 3'b001;
    drive_run(7'b1010101, sm, -1, 1'b1);
    checks++;
    if (np_at[20] !== 7'b1010101) begin
      errors++; $display("FAIL restart_pixels: got %b need 1010101", np_at[20]);
    end
    checks++;
    if (done_mask[21:0] !== 22'h200000) begin
      errors++; $display("FAIL restart_single_done: got %h need 200000", done_mask[21:0]);
    end
    checks++;
    if (busy_mask[22] !== 1'b0 || busy_mask[23] !== 1'b1 || en_mask[24] !== 1'b1) begin
      errors++;
      $display("FAIL restart_accept22: busy22=%b busy23=%b en24=%b, need 0 1 1",
               busy_mask[22], busy_mask[23], en_mask[24]);
    end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1 || bus.net_pixels !== 7'b0000000) begin
      errors++;
      $display("FAIL restart_second_run: done_seen=%b pix=%b, need 1 0000000", seen, bus.net_pixels);
    end
  endtask

  task automatic test_mid_run_reset();
    for (int i = 0; i < 16; i++) spk_tbl[i] = 3'b111;
    drive_run(7'b1100110, 32'h0, 8, 1'b0);
    checks++;
    if (busy_mask[9] !== 1'b0 || en_mask[9] !== 1'b0 || nrst_at[9] !== 1'b1 || cnt_at[9] !== 12'h000) begin
      errors++;
      $display("FAIL rst_mid_run: busy=%b en=%b net_rst=%b counts=%h, need 0 0 1 000",
               busy_mask[9], en_mask[9], nrst_at[9], cnt_at[9]);
    end
    checks++;
    if (done_mask !== 32'h0 || cnt_at[20] !== 12'h000) begin
      errors++;
      $display("FAIL rst_no_done: done_mask=%h counts20=%h, need 0 000", done_mask, cnt_at[20]);
    end
    for (int i = 0; i < 16; i++) spk_tbl[i] = (i < 6) ? 3'b100 : 3'b000;
    drive_run(7'b0011001, 32'h0, -1, 1'b0);
    checks++;
    if (done_mask !== 32'h00200000 || bus.spike_counts !== 12'h600 || bus.winner !== 2'd2) begin
      errors++;
      $display("FAIL rst_fresh_run: done=%h counts=%h winner=%0d, need 00200000 600 2",
               done_mask, bus.spike_counts, bus.winner);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.pixels = '0;
    bus.net_spikes = '0;
    rst = 1'b1;
    test_reset();
    test_saturate();
    test_tie();
    test_last_class_wins();
    test_no_spike();
    test_start_ignored();
    test_mid_run_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
